// File: rtl/wisc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wisc_pkg
// Purpose  : Opcode and condition-code encodings plus flag-class decode.
// Revision : 1.0
// ============================================================================
package wisc_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_PADDSB = 4'h1;
  localparam logic [3:0] OP_SUB    = 4'h2;
  localparam logic [3:0] OP_AND    = 4'h3;
  localparam logic [3:0] OP_NOR    = 4'h4;
  localparam logic [3:0] OP_SLL    = 4'h5;
  localparam logic [3:0] OP_SRL    = 4'h6;
  localparam logic [3:0] OP_SRA    = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LHB    = 4'hA;
  localparam logic [3:0] OP_LLB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_JAL    = 4'hD;
  localparam logic [3:0] OP_JR     = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  localparam logic [2:0] CCC_NEQ    = 3'b000;
  localparam logic [2:0] CCC_EQ     = 3'b001;
  localparam logic [2:0] CCC_GT     = 3'b010;
  localparam logic [2:0] CCC_LT     = 3'b011;
  localparam logic [2:0] CCC_GTE    = 3'b100;
  localparam logic [2:0] CCC_LTE    = 3'b101;
  localparam logic [2:0] CCC_OVFL   = 3'b110;
  localparam logic [2:0] CCC_UNCOND = 3'b111;

  function automatic logic sets_zvn(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic sets_z_only(input logic [3:0] op);
    return (op == OP_AND) || (op == OP_NOR) || (op == OP_SLL) ||
           (op == OP_SRL) || (op == OP_SRA);
  endfunction

  // Arithmetic ops whose result comes from the au rather than the logic path.
  function automatic logic uses_au(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_PADDSB);
  endfunction

endpackage
`default_nettype wire

// File: rtl/br_cond_eval.sv
`default_nettype none
// ============================================================================
// Module   : br_cond_eval
// Purpose  : Branch condition evaluation against committed Z/V/N flags.
// Revision : 1.0
// ============================================================================
module br_cond_eval
  import wisc_pkg::*;
(
  input  logic [2:0] ccc_i,
  input  logic       z_i,
  input  logic       v_i,
  input  logic       n_i,
  output logic       cond_o
);

  always_comb begin
    cond_o = 1'b0;
    case (ccc_i)
      CCC_NEQ:    cond_o = ~z_i;
      CCC_EQ:     cond_o = z_i;
      CCC_GT:     cond_o = ~z_i & ~n_i;
      CCC_LT:     cond_o = n_i;
      CCC_GTE:    cond_o = z_i | (~z_i & ~n_i);
      CCC_LTE:    cond_o = n_i | z_i;
      CCC_OVFL:   cond_o = v_i;
      CCC_UNCOND: cond_o = 1'b1;
      default:    cond_o = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ex_flag_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_flag_stage
// Purpose  : EX/MEM pipeline register, Z/V/N flag register, branch resolve, halt.
// Revision : 1.0
// ============================================================================
module ex_flag_stage
  import wisc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [3:0]        ex_op,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_we,
  input  logic [2:0]        ex_ccc,
  input  logic [DATA_W-1:0] au_result,
  input  logic              au_v,
  input  logic              au_n,
  input  logic [DATA_W-1:0] lg_result,
  output logic              mem_valid,
  output logic [3:0]        mem_op,
  output logic [REG_AW-1:0] mem_rd,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_result,
  output logic              flag_z,
  output logic              flag_v,
  output logic              flag_n,
  output logic              br_taken,
  output logic              halted
);

  logic              valid_q,  valid_d;
  logic [3:0]        op_q,     op_d;
  logic [REG_AW-1:0] rd_q,     rd_d;
  logic              we_q,     we_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              z_q, z_d, v_q, v_d, n_q, n_d;
  logic              halted_q, halted_d;
  logic              cond;

  br_cond_eval u_br_cond_eval (
    .ccc_i  (ex_ccc),
    .z_i    (z_q),
    .v_i    (v_q),
    .n_i    (n_q),
    .cond_o (cond)
  );

  // Condition sees only committed flags; the EX instruction's own flags are not forwarded.
  assign br_taken = ex_valid & (ex_op == OP_B) & ~flush & cond;

  always_comb begin
    valid_d  = valid_q;
    op_d     = op_q;
    rd_d     = rd_q;
    we_d     = we_q;
    result_d = result_q;
    z_d      = z_q;
    v_d      = v_q;
    n_d      = n_q;
    halted_d = halted_q;

    if (flush) begin
      valid_d = 1'b0;
      we_d    = 1'b0;
    end else if (!stall) begin
      if (ex_valid && !halted_q) begin
        valid_d  = 1'b1;
        op_d     = ex_op;
        rd_d     = ex_rd;
        we_d     = ex_we;
        result_d = uses_au(ex_op) ? au_result : lg_result;
        if (sets_zvn(ex_op)) begin
          z_d = (au_result == '0);
          v_d = au_v;
          n_d = au_n;
        end else if (sets_z_only(ex_op)) begin
          z_d = (lg_result == '0);
        end
        if (ex_op == OP_HLT) begin
          halted_d = 1'b1;
        end
      end else begin
        // Empty EX slot, or machine halted: only bubbles enter EX/MEM.
        valid_d = 1'b0;
        we_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      op_q     <= '0;
      rd_q     <= '0;
      we_q     <= 1'b0;
      result_q <= '0;
      z_q      <= 1'b0;
      v_q      <= 1'b0;
      n_q      <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      we_q     <= we_d;
      result_q <= result_d;
      z_q      <= z_d;
      v_q      <= v_d;
      n_q      <= n_d;
      halted_q <= halted_d;
    end
  end

  assign mem_valid  = valid_q;
  assign mem_op     = op_q;
  assign mem_rd     = rd_q;
  assign mem_we     = we_q;
  assign mem_result = result_q;
  assign flag_z     = z_q;
  assign flag_v     = v_q;
  assign flag_n     = n_q;
  assign halted     = halted_q;

endmodule
`default_nettype wire
